// File: rtl/mario_motion.sv
// Per-frame motion integrator for Mario: velocity update, position update with playfield clamping.
// Optional macro MARIO_GRAVITY_EN adds +1 to the vertical velocity every frame while airborne.
module mario_motion #(
  parameter int POS_W    = 10,
  parameter int VEL_W    = 6,
  parameter int START_X  = 320,
  parameter int START_Y  = 400,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 623,
  parameter int Y_MIN    = 0,
  parameter int Y_GROUND = 400,
  parameter int VMAX_X   = 8,
  parameter int VMAX_Y   = 15
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_clk,
  input  logic [2:0]       right_accel,
  input  logic [2:0]       left_accel,
  input  logic [2:0]       up_accel,
  input  logic [2:0]       down_accel,
  input  logic             stand_still,
  output logic [POS_W-1:0] Mario_X,
  output logic [POS_W-1:0] Mario_Y,
  output logic [VEL_W-1:0] Vel_X,
  output logic [VEL_W-1:0] Vel_Y,
  output logic             is_ground,
  output logic             facing_left,
  output logic             update_done
);

  localparam int VW = VEL_W + 2;
  localparam int PW = POS_W + 2;

  localparam logic signed [VW-1:0] VX_HI = VW'(VMAX_X);
  localparam logic signed [VW-1:0] VX_LO = -VX_HI;
  localparam logic signed [VW-1:0] VY_HI = VW'(VMAX_Y);
  localparam logic signed [VW-1:0] VY_LO = -VY_HI;

  localparam logic signed [PW-1:0] XMIN_S = PW'(X_MIN);
  localparam logic signed [PW-1:0] XMAX_S = PW'(X_MAX);
  localparam logic signed [PW-1:0] YMIN_S = PW'(Y_MIN);
  localparam logic signed [PW-1:0] YGND_S = PW'(Y_GROUND);

  typedef enum logic [1:0] {WAIT_FRAME, UPD_VEL, UPD_POS, DONE} state_t;

  state_t state, state_nxt;
  logic   frame_q;
  logic   frame_edge;

  assign frame_edge = frame_clk & ~frame_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= WAIT_FRAME;
      frame_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      frame_q <= frame_clk;
    end
  end

  // Edges arriving outside WAIT_FRAME are simply dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_FRAME: if (frame_edge) state_nxt = UPD_VEL;
      UPD_VEL:    state_nxt = UPD_POS;
      UPD_POS:    state_nxt = DONE;
      DONE:       state_nxt = WAIT_FRAME;
      default:    state_nxt = WAIT_FRAME;
    endcase
  end

  // Velocity datapath, widened by two bits so accel sums never wrap before saturation.
  logic signed [VW-1:0] vel_x_ext, vel_y_ext;
  logic signed [VW-1:0] r_ext, l_ext, u_ext, d_ext, grav;
  logic signed [VW-1:0] vx_sum, vy_sum, vx_sat, vy_sat;

  assign vel_x_ext = {{2{Vel_X[VEL_W-1]}}, Vel_X};
  assign vel_y_ext = {{2{Vel_Y[VEL_W-1]}}, Vel_Y};
  assign r_ext     = {{(VW-3){1'b0}}, right_accel};
  assign l_ext     = {{(VW-3){1'b0}}, left_accel};
  assign u_ext     = {{(VW-3){1'b0}}, up_accel};
  assign d_ext     = {{(VW-3){1'b0}}, down_accel};

`ifdef MARIO_GRAVITY_EN
  assign grav = is_ground ? '0 : VW'(1);
`else
  assign grav = '0;
`endif

  assign vx_sum = vel_x_ext + r_ext - l_ext;
  assign vy_sum = vel_y_ext + d_ext - u_ext + grav;

  always_comb begin
    if (stand_still)          vx_sat = '0;
    else if (vx_sum > VX_HI)  vx_sat = VX_HI;
    else if (vx_sum < VX_LO)  vx_sat = VX_LO;
    else                      vx_sat = vx_sum;

    if (vy_sum > VY_HI)       vy_sat = VY_HI;
    else if (vy_sum < VY_LO)  vy_sat = VY_LO;
    else                      vy_sat = vy_sum;
  end

  // Position datapath uses the velocity registered in UPD_VEL (semi-implicit Euler).
  logic signed [PW-1:0] x_sum, y_sum;
  logic [POS_W-1:0]     x_nxt, y_nxt;
  logic                 x_hit, y_hit;

  assign x_sum = $signed({2'b00, Mario_X}) + $signed({{(PW-VEL_W){Vel_X[VEL_W-1]}}, Vel_X});
  assign y_sum = $signed({2'b00, Mario_Y}) + $signed({{(PW-VEL_W){Vel_Y[VEL_W-1]}}, Vel_Y});

  always_comb begin
    x_hit = 1'b1;
    if (x_sum < XMIN_S)       x_nxt = POS_W'(X_MIN);
    else if (x_sum > XMAX_S)  x_nxt = POS_W'(X_MAX);
    else begin
      x_nxt = POS_W'(x_sum);
      x_hit = 1'b0;
    end

    y_hit = 1'b1;
    if (y_sum >= YGND_S)      y_nxt = POS_W'(Y_GROUND);
    else if (y_sum < YMIN_S)  y_nxt = POS_W'(Y_MIN);
    else begin
      y_nxt = POS_W'(y_sum);
      y_hit = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Mario_X     <= POS_W'(START_X);
      Mario_Y     <= POS_W'(START_Y);
      Vel_X       <= '0;
      Vel_Y       <= '0;
      is_ground   <= (START_Y == Y_GROUND);
      facing_left <= 1'b0;
      update_done <= 1'b0;
    end else begin
      update_done <= (state == UPD_POS);
      case (state)
        UPD_VEL: begin
          Vel_X <= VEL_W'(vx_sat);
          Vel_Y <= VEL_W'(vy_sat);
          if (vx_sat < 0)       facing_left <= 1'b1;
          else if (vx_sat > 0)  facing_left <= 1'b0;
        end
        UPD_POS: begin
          Mario_X   <= x_nxt;
          Mario_Y   <= y_nxt;
          is_ground <= (y_nxt == POS_W'(Y_GROUND));
          if (x_hit) Vel_X <= '0;
          if (y_hit) Vel_Y <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mario_motion.sv
// Self-checking bench for mario_motion against a frame-level integer model.
module tb_mario_motion;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic [2:0] right_accel, left_accel, up_accel, down_accel;
  logic       stand_still;
  logic [9:0] Mario_X, Mario_Y;
  logic [5:0] Vel_X, Vel_Y;
  logic       is_ground, facing_left, update_done;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_x, m_y, m_vx, m_vy;
  bit m_face, m_gnd;

  always #5 Clk = ~Clk;

  mario_motion dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .right_accel(right_accel), .left_accel(left_accel),
    .up_accel(up_accel), .down_accel(down_accel), .stand_still(stand_still),
    .Mario_X(Mario_X), .Mario_Y(Mario_Y), .Vel_X(Vel_X), .Vel_Y(Vel_Y),
    .is_ground(is_ground), .facing_left(facing_left), .update_done(update_done)
  );

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic void model_reset();
    m_x = 320; m_y = 400; m_vx = 0; m_vy = 0; m_face = 0; m_gnd = 1;
  endfunction

  // One frame of motion, straight from the rules: velocity first, then position.
  function automatic void model_frame(int r, int l, int u, int d, bit ss);
    m_vx = ss ? 0 : clampi(m_vx + r - l, -8, 8);
    m_vy = clampi(m_vy + d - u, -15, 15);
    if (m_vx < 0) m_face = 1;
    else if (m_vx > 0) m_face = 0;
    m_x = m_x + m_vx;
    if (m_x < 0)        begin m_x = 0;   m_vx = 0; end
    else if (m_x > 623) begin m_x = 623; m_vx = 0; end
    m_y = m_y + m_vy;
    if (m_y >= 400)     begin m_y = 400; m_vy = 0; end
    else if (m_y < 0)   begin m_y = 0;   m_vy = 0; end
    m_gnd = (m_y == 400);
  endfunction

  task automatic apply_reset();
    frame_clk = 0; right_accel = 0; left_accel = 0; up_accel = 0; down_accel = 0;
    stand_still = 0; Reset_n = 0;
    repeat (3) @(negedge Clk);
    Reset_n = 1;
    @(negedge Clk);
    model_reset();
  endtask

  // Drives one frame edge, counts update_done pulses in a bounded window, steps the model.
  task automatic run_frame(input int r, input int l, input int u, input int d,
                           input bit ss, output int pulses);
    right_accel = 3'(r); left_accel = 3'(l); up_accel = 3'(u); down_accel = 3'(d);
    stand_still = ss;
    frame_clk = 1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (c == 2) frame_clk = 0;
      if (update_done) pulses++;
    end
    model_frame(r, l, u, d, ss);
  endtask

  task automatic test_reset();
    Reset_n = 0; frame_clk = 0; right_accel = 0; left_accel = 0; up_accel = 0;
    down_accel = 0; stand_still = 0;
    repeat (3) @(negedge Clk);
    Reset_n = 1;
    @(negedge Clk);
    model_reset();
    checks++;
    if (Mario_X !== 10'd320 || Mario_Y !== 10'd400 || Vel_X !== 6'd0 || Vel_Y !== 6'd0 ||
        is_ground !== 1'b1 || facing_left !== 1'b0 || update_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got X=%0d Y=%0d VX=%0d VY=%0d gnd=%b face=%b done=%b, need 320 400 0 0 1 0 0",
               Mario_X, Mario_Y, Vel_X, Vel_Y, is_ground, facing_left, update_done);
    end
  endtask

  task automatic test_right_accel();
    int p;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      run_frame(2, 0, 0, 0, 0, p);
      checks++;
      if (p !== 1) begin errors++; $display("FAIL right_pulses f%0d: got %0d need 1", f, p); end
      checks++;
      if ($signed(Vel_X) !== m_vx || int'(Mario_X) !== m_x || facing_left !== m_face) begin
        errors++;
        $display("FAIL right f%0d: got VX=%0d X=%0d face=%b need VX=%0d X=%0d face=%b",
                 f, $signed(Vel_X), Mario_X, facing_left, m_vx, m_x, m_face);
      end
    end
  endtask

  task automatic test_saturation();
    int p;
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      run_frame(3, 0, 0, 0, 0, p);
      checks++;
      if ($signed(Vel_X) !== m_vx || int'(Mario_X) !== m_x || p !== 1) begin
        errors++;
        $display("FAIL sat f%0d: got VX=%0d X=%0d pulses=%0d need VX=%0d X=%0d pulses=1",
                 f, $signed(Vel_X), Mario_X, p, m_vx, m_x);
      end
    end
  endtask

  task automatic test_jump();
    int p;
    apply_reset();
    run_frame(0, 0, 7, 0, 0, p);
    checks++;
    if ($signed(Vel_Y) !== -7 || Mario_Y !== 10'd393 || is_ground !== 1'b0) begin
      errors++;
      $display("FAIL jump_start: got VY=%0d Y=%0d gnd=%b need -7 393 0",
               $signed(Vel_Y), Mario_Y, is_ground);
    end
    for (int f = 2; f <= 15; f++) begin
      run_frame(0, 0, 0, 1, 0, p);
      checks++;
      if ($signed(Vel_Y) !== m_vy || int'(Mario_Y) !== m_y || is_ground !== m_gnd) begin
        errors++;
        $display("FAIL jump f%0d: got VY=%0d Y=%0d gnd=%b need VY=%0d Y=%0d gnd=%b",
                 f, $signed(Vel_Y), Mario_Y, is_ground, m_vy, m_y, m_gnd);
      end
    end
    checks++;
    if (Mario_Y !== 10'd400 || Vel_Y !== 6'd0 || is_ground !== 1'b1) begin
      errors++;
      $display("FAIL land: got Y=%0d VY=%0d gnd=%b need 400 0 1", Mario_Y, $signed(Vel_Y), is_ground);
    end
  endtask

  task automatic test_left_clamp();
    int p;
    int guard;
    apply_reset();
    guard = 0;
    while (m_x > 0 && guard < 100) begin
      run_frame(0, 7, 0, 0, 0, p);
      guard++;
    end
    checks++;
    if (Mario_X !== 10'd0 || Vel_X !== 6'd0 || facing_left !== 1'b1) begin
      errors++;
      $display("FAIL left_clamp: got X=%0d VX=%0d face=%b need 0 0 1",
               Mario_X, $signed(Vel_X), facing_left);
    end
    run_frame(3, 0, 0, 0, 1, p);
    checks++;
    if (Mario_X !== 10'd0 || Vel_X !== 6'd0 || facing_left !== 1'b1) begin
      errors++;
      $display("FAIL stand_still: got X=%0d VX=%0d face=%b need 0 0 1",
               Mario_X, $signed(Vel_X), facing_left);
    end
  endtask

  task automatic test_reset_mid_update();
    apply_reset();
    right_accel = 3;
    frame_clk = 1;
    repeat (2) @(negedge Clk);  // now in the position-update cycle
    Reset_n = 0;
    #1;
    checks++;
    if (Mario_X !== 10'd320 || Vel_X !== 6'd0 || facing_left !== 1'b0 || update_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got X=%0d VX=%0d face=%b done=%b need 320 0 0 0",
               Mario_X, $signed(Vel_X), facing_left, update_done);
    end
    frame_clk = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1;
    repeat (5) @(negedge Clk);
    model_reset();
    checks++;
    if (Mario_X !== 10'd320 || Vel_X !== 6'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got X=%0d VX=%0d need 320 0", Mario_X, $signed(Vel_X));
    end
  endtask

  task automatic test_double_edge();
    int p;
    apply_reset();
    right_accel = 2;
    p = 0;
    frame_clk = 1; @(negedge Clk); if (update_done) p++;
    frame_clk = 0; @(negedge Clk); if (update_done) p++;
    frame_clk = 1; @(negedge Clk); if (update_done) p++;
    frame_clk = 0;
    repeat (8) begin @(negedge Clk); if (update_done) p++; end
    model_frame(2, 0, 0, 0, 0);
    checks++;
    if (p !== 1 || $signed(Vel_X) !== m_vx || int'(Mario_X) !== m_x) begin
      errors++;
      $display("FAIL double_edge: got pulses=%0d VX=%0d X=%0d need 1 %0d %0d",
               p, $signed(Vel_X), Mario_X, m_vx, m_x);
    end
  endtask

  task automatic test_random();
    int p, r, l, u, d;
    bit ss;
    apply_reset();
    for (int f = 0; f < 60; f++) begin
      r = $urandom_range(0, 7); l = $urandom_range(0, 7);
      u = $urandom_range(0, 7); d = $urandom_range(0, 7);
      ss = ($urandom_range(0, 9) == 0);
      run_frame(r, l, u, d, ss, p);
      checks++;
      if (p !== 1 || $signed(Vel_X) !== m_vx || $signed(Vel_Y) !== m_vy ||
          int'(Mario_X) !== m_x || int'(Mario_Y) !== m_y ||
          is_ground !== m_gnd || facing_left !== m_face) begin
        errors++;
        $display("FAIL random f%0d: got p=%0d VX=%0d VY=%0d X=%0d Y=%0d g=%b f=%b need p=1 VX=%0d VY=%0d X=%0d Y=%0d g=%b f=%b",
                 f, p, $signed(Vel_X), $signed(Vel_Y), Mario_X, Mario_Y, is_ground, facing_left,
                 m_vx, m_vy, m_x, m_y, m_gnd, m_face);
      end
    end
  endtask

  initial begin
    test_reset();
    test_right_accel();
    test_saturation();
    test_jump();
    test_left_clamp();
    test_reset_mid_update();
    test_double_edge();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
